build_info_regs: RTL and testbench

Parametrised build-identification register block. It presents the build git hash, the configuration-time USR_ACCESS timestamp and N user words as a read-only, word-addressed register file with a request/acknowledge read port. It sits beside the build-hash generator and the USR_ACCESS primitive wrapper in the BD. It replaces direct wiring of those values with debounced capture plus a self-describing status word.

---
 rtl/build_info_pkg.sv | 30 +++
 rtl/usr_access_capture.sv | 114 +++++++++++
 rtl/build_info_regs.sv | 122 ++++++++++++
 tb/tb_build_info_regs.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/build_info_pkg.sv
// Shared definitions for the build-identification register block.
// Holds the default identification word, the fixed word offsets at the
// bottom of the register map, status word bit positions, a helper to size
// the map, and the timestamp capture FSM state type.
package build_info_pkg;

    localparam logic [31:0] ID_WORD_DEFAULT = 32'hB1D0_0001;

    // Fixed word offsets; the hash words start at ADDR_HASH0.
    localparam int ADDR_ID     = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_HASH0  = 2;

    // Status word layout.
    localparam int STATUS_VALID_BIT = 0;
    localparam int STATUS_HW_LSB    = 8;
    localparam int STATUS_NUSER_LSB = 16;

    // ID + status + hash words + timestamp + user words.
    function automatic int num_words(input int hash_w, input int num_user);
        return 3 + (hash_w / 32) + num_user;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURED
    } cap_state_e;

endpackage

// File: rtl/usr_access_capture.sv
// USR_ACCESS timestamp capture.
// Synchronises DATAVALID through two flops, registers DATA once, and only
// captures DATA once it has been seen stable (with DATAVALID high) for
// STABLE_CYCLES consecutive cycles. After capture the block is frozen until
// reset.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   data_i          USR_ACCESS DATA (asynchronous)
//   datavalid_i     USR_ACCESS DATAVALID (asynchronous)
//   timestamp_o     captured DATA value, 0 until capture
//   info_valid_o    high once the timestamp has been captured
module usr_access_capture
    import build_info_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_i,
    input  logic        datavalid_i,
    output logic [31:0] timestamp_o,
    output logic        info_valid_o
);

    logic        dv_meta_q,    dv_meta_d;
    logic        dv_sync_q,    dv_sync_d;
    logic [31:0] data_q,       data_d;
    logic [31:0] cmp_q,        cmp_d;
    logic [7:0]  cnt_q,        cnt_d;
    cap_state_e  state_q,      state_d;
    logic [31:0] timestamp_q,  timestamp_d;
    logic        info_valid_q, info_valid_d;

    always_comb begin
        dv_meta_d    = datavalid_i;
        dv_sync_d    = dv_meta_q;
        // DATA gets a single register stage; it is never used on its own,
        // only through the stability comparison, so metastability on one
        // sample just restarts the stable window.
        data_d       = data_i;
        cmp_d        = cmp_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        timestamp_d  = timestamp_q;
        info_valid_d = info_valid_q;

        case (state_q)
            IDLE: begin
                if (dv_sync_q) begin
                    cmp_d = data_q;
                    cnt_d = 8'd1;
                    // The first valid sample already counts as one stable cycle.
                    if (STABLE_CYCLES == 1) begin
                        state_d      = CAPTURED;
                        timestamp_d  = data_q;
                        info_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!dv_sync_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (data_q != cmp_q) begin
                    // Restart the stable window on the new value.
                    cmp_d = data_q;
                    cnt_d = 8'd1;
                end else if (cnt_q + 8'd1 == 8'(STABLE_CYCLES)) begin
                    cnt_d        = cnt_q + 8'd1;
                    state_d      = CAPTURED;
                    timestamp_d  = cmp_q;
                    info_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CAPTURED: begin
                state_d = CAPTURED;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dv_meta_q    <= 1'b0;
            dv_sync_q    <= 1'b0;
            data_q       <= '0;
            cmp_q        <= '0;
            cnt_q        <= '0;
            state_q      <= IDLE;
            timestamp_q  <= '0;
            info_valid_q <= 1'b0;
        end else begin
            dv_meta_q    <= dv_meta_d;
            dv_sync_q    <= dv_sync_d;
            data_q       <= data_d;
            cmp_q        <= cmp_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            timestamp_q  <= timestamp_d;
            info_valid_q <= info_valid_d;
        end
    end

    assign timestamp_o  = timestamp_q;
    assign info_valid_o = info_valid_q;

endmodule

// File: rtl/build_info_regs.sv
// Build-identification register block.
// Read-only word-addressed register file exposing: an ID constant, a
// self-describing status word, the build git hash (LS word first), the
// USR_ACCESS timestamp and NUM_USER static user words. Reads have a fixed
// one-cycle latency and are fully pipelined.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   hash_i                   build git hash (static)
//   usr_access_data_i        USR_ACCESS DATA (asynchronous)
//   usr_access_datavalid_i   USR_ACCESS DATAVALID (asynchronous)
//   user_words_i             static user words, word k at [32k+31:32k]
//   rd_req_i, rd_addr_i      read request / word address
//   rd_ack_o, rd_data_o      read acknowledge / data (data holds when idle)
//   rd_err_o                 address out of range, valid with rd_ack_o
//   info_valid_o             timestamp captured
//   timestamp_o              captured timestamp
module build_info_regs
    import build_info_pkg::*;
#(
    parameter int          HASH_W        = 64,
    parameter int          NUM_USER      = 2,
    parameter int          STABLE_CYCLES = 16,
    parameter logic [31:0] ID_WORD       = ID_WORD_DEFAULT,
    parameter int          AW            = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [HASH_W-1:0]        hash_i,
    input  logic [31:0]              usr_access_data_i,
    input  logic                     usr_access_datavalid_i,
    input  logic [NUM_USER*32-1:0]   user_words_i,
    input  logic                     rd_req_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic                     rd_ack_o,
    output logic [31:0]              rd_data_o,
    output logic                     rd_err_o,
    output logic                     info_valid_o,
    output logic [31:0]              timestamp_o
);

    localparam int HW         = HASH_W / 32;
    localparam int NUM_WORDS  = num_words(HASH_W, NUM_USER);
    localparam int ADDR_TS    = ADDR_HASH0 + HW;
    localparam int ADDR_USER0 = ADDR_TS + 1;
    localparam int MAP_DEPTH  = 2 ** AW;

    usr_access_capture #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_capture (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (usr_access_data_i),
        .datavalid_i  (usr_access_datavalid_i),
        .timestamp_o  (timestamp_o),
        .info_valid_o (info_valid_o)
    );

    logic [31:0] status_word;

    always_comb begin
        status_word                            = '0;
        status_word[STATUS_VALID_BIT]          = info_valid_o;
        status_word[STATUS_HW_LSB +: 8]        = 8'(HW);
        status_word[STATUS_NUSER_LSB +: 8]     = 8'(NUM_USER);
    end

    // The map covers the full address space so the read index needs no
    // width adaptation; unused slots read as 0 and are flagged by rd_err.
    logic [31:0] word_map [MAP_DEPTH];

    for (genvar gi = 0; gi < MAP_DEPTH; gi++) begin : g_word
        if (gi == ADDR_ID) begin : g_id
            assign word_map[gi] = ID_WORD;
        end else if (gi == ADDR_STATUS) begin : g_status
            assign word_map[gi] = status_word;
        end else if (gi < ADDR_TS) begin : g_hash
            assign word_map[gi] = hash_i[32*(gi-ADDR_HASH0) +: 32];
        end else if (gi == ADDR_TS) begin : g_ts
            assign word_map[gi] = timestamp_o;
        end else if (gi < NUM_WORDS) begin : g_user
            assign word_map[gi] = user_words_i[32*(gi-ADDR_USER0) +: 32];
        end else begin : g_unused
            assign word_map[gi] = '0;
        end
    end

    logic        rd_ack_q,  rd_ack_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_err_q,  rd_err_d;

    always_comb begin
        rd_ack_d  = rd_req_i;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if (rd_req_i) begin
            if (32'(rd_addr_i) < 32'(NUM_WORDS)) begin
                rd_data_d = word_map[rd_addr_i];
                rd_err_d  = 1'b0;
            end else begin
                rd_data_d = '0;
                rd_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rd_ack_o  = rd_ack_q;
    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;

endmodule

// File: tb/tb_build_info_regs.sv
// Bench for build_info_regs with default parameters (HASH_W=64, NUM_USER=2,
// STABLE_CYCLES=16, AW=4, NUM_WORDS=7). Read expectations are queued when a
// request is driven and popped when the acknowledge appears.
module tb_build_info_regs;

    logic        clk;
    logic        rst_n;
    logic [63:0] hash_i;
    logic [31:0] usr_access_data_i;
    logic        usr_access_datavalid_i;
    logic [63:0] user_words_i;
    logic        rd_req_i;
    logic [3:0]  rd_addr_i;
    logic        rd_ack_o;
    logic [31:0] rd_data_o;
    logic        rd_err_o;
    logic        info_valid_o;
    logic [31:0] timestamp_o;

    build_info_regs dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .hash_i                 (hash_i),
        .usr_access_data_i      (usr_access_data_i),
        .usr_access_datavalid_i (usr_access_datavalid_i),
        .user_words_i           (user_words_i),
        .rd_req_i               (rd_req_i),
        .rd_addr_i              (rd_addr_i),
        .rd_ack_o               (rd_ack_o),
        .rd_data_o              (rd_data_o),
        .rd_err_o               (rd_err_o),
        .info_valid_o           (info_valid_o),
        .timestamp_o            (timestamp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [3:0]  addr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    logic [31:0] last_data = '0;
    logic        last_err = 1'b0;

    // Advance one clock: inputs are driven at the negedge, outputs are
    // sampled at the following negedge, and the read port is scoreboarded.
    task automatic step();
        logic req_pre;
        logic rst_pre;
        logic exp_ack;
        exp_t e;
        req_pre = rd_req_i;
        rst_pre = rst_n;
        @(posedge clk);
        @(negedge clk);
        if (mon_en) begin
            exp_ack = req_pre && rst_pre;
            if (!rst_pre) begin
                last_data = '0;
                last_err  = 1'b0;
            end
            if (exp_ack || rd_ack_o !== 1'b0) begin
                checks++;
                if (rd_ack_o !== exp_ack) begin
                    errors++;
                    $display("FAIL rd_ack: got %b want %b at %0t", rd_ack_o, exp_ack, $time);
                end
            end
            if (exp_ack) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: request without queued expectation at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    if (rd_ack_o === 1'b1) begin
                        checks++;
                        if (rd_data_o !== e.data || rd_err_o !== e.err) begin
                            errors++;
                            $display("FAIL read addr %0d: got data %h err %b want data %h err %b",
                                     e.addr, rd_data_o, rd_err_o, e.data, e.err);
                        end else begin
                            $display("read addr %0d -> data %h err %b", e.addr, rd_data_o, rd_err_o);
                        end
                    end
                    last_data = e.data;
                    last_err  = e.err;
                end
            end else begin
                checks++;
                if (rd_data_o !== last_data || rd_err_o !== last_err) begin
                    errors++;
                    $display("FAIL hold: got data %h err %b want data %h err %b",
                             rd_data_o, rd_err_o, last_data, last_err);
                end
            end
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [31:0] d, input logic er);
        exp_t e;
        rd_req_i  = 1'b1;
        rd_addr_i = a;
        e.addr = a;
        e.data = d;
        e.err  = er;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        rd_req_i               = 1'b0;
        usr_access_datavalid_i = 1'b0;
        rst_n                  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        mon_en = 1;
        step();
        checks++;
        if (rd_ack_o !== 1'b0 || rd_data_o !== 32'h0 || rd_err_o !== 1'b0 ||
            info_valid_o !== 1'b0 || timestamp_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: ack %b data %h err %b valid %b ts %h want all 0",
                     rd_ack_o, rd_data_o, rd_err_o, info_valid_o, timestamp_o);
        end else begin
            $display("reset values ok");
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        issue(4'd0, 32'hB1D0_0001, 1'b0);
        step();
        issue(4'd1, 32'h0002_0200, 1'b0);
        step();
        rd_req_i = 1'b0;
        step();
    endtask

    task automatic test_hash();
        issue(4'd2, 32'h89AB_CDEF, 1'b0);
        step();
        issue(4'd3, 32'h0123_4567, 1'b0);
        step();
        rd_req_i = 1'b0;
        step();
    endtask

    task automatic test_range_and_user();
        issue(4'd9,  32'h0, 1'b1);           step();
        issue(4'd6,  32'hCAFE_F00D, 1'b0);   step();
        issue(4'd7,  32'h0, 1'b1);           step();
        issue(4'd5,  32'h1234_5678, 1'b0);   step();
        issue(4'd15, 32'h0, 1'b1);           step();
        issue(4'd4,  32'h0, 1'b0);           step();
        rd_req_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_short_pulse();
        usr_access_data_i      = 32'hAAAA_5555;
        usr_access_datavalid_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        usr_access_datavalid_i = 1'b0;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (info_valid_o !== 1'b0 || timestamp_o !== 32'h0) begin
            errors++;
            $display("FAIL short_pulse: valid %b ts %h want 0 00000000", info_valid_o, timestamp_o);
        end else begin
            $display("short datavalid pulse: no capture");
        end
    endtask

    task automatic test_data_change();
        int n;
        usr_access_data_i      = 32'h5555_0000;
        usr_access_datavalid_i = 1'b1;
        for (int i = 0; i < 12; i++) step();
        usr_access_data_i = 32'h0000_0011;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (info_valid_o === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 17 || timestamp_o !== 32'h0000_0011) begin
            errors++;
            $display("FAIL data_change: captured after %0d edges ts %h want 17 edges ts 00000011",
                     n, timestamp_o);
        end else begin
            $display("data change: capture after %0d edges ts %h", n, timestamp_o);
        end
        // Capture is terminal: later input activity must not disturb it.
        usr_access_data_i = 32'h0000_0022;
        for (int i = 0; i < 25; i++) step();
        usr_access_datavalid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (info_valid_o !== 1'b1 || timestamp_o !== 32'h0000_0011) begin
            errors++;
            $display("FAIL captured_hold: valid %b ts %h want 1 00000011", info_valid_o, timestamp_o);
        end
        issue(4'd4, 32'h0000_0011, 1'b0); step();
        issue(4'd1, 32'h0002_0201, 1'b0); step();
        rd_req_i = 1'b0;
        step();
    endtask

    // Drives a stable timestamp from reset release and reads the timestamp
    // word on the capture edge itself; that read must see the old value.
    task automatic capture_window(input logic [31:0] val, input string tag);
        int n;
        usr_access_data_i      = val;
        usr_access_datavalid_i = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 18) issue(4'd4, 32'h0, 1'b0);
            else         rd_req_i = 1'b0;
            step();
            if (info_valid_o === 1'b1) begin
                n = i;
                break;
            end
        end
        rd_req_i = 1'b0;
        checks++;
        if (n != 18 || timestamp_o !== val) begin
            errors++;
            $display("FAIL %s: captured after %0d edges ts %h want 18 edges ts %h",
                     tag, n, timestamp_o, val);
        end else begin
            $display("%s: capture after %0d edges ts %h", tag, n, timestamp_o);
        end
        step();
        issue(4'd4, val, 1'b0);           step();
        issue(4'd1, 32'h0002_0201, 1'b0); step();
        rd_req_i = 1'b0;
        step();
    endtask

    task automatic test_capture();
        apply_reset();
        capture_window(32'h5F3A_1200, "capture");
    endtask

    task automatic test_reset_mid();
        // Request and reset land on the same edge: no acknowledge may follow.
        rd_req_i  = 1'b1;
        rd_addr_i = 4'd0;
        rst_n     = 1'b0;
        step();
        rd_req_i = 1'b0;
        checks++;
        if (info_valid_o !== 1'b0 || timestamp_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: valid %b ts %h want 0 00000000", info_valid_o, timestamp_o);
        end else begin
            $display("reset mid-operation: state cleared");
        end
        step();
        rst_n = 1'b1;
        capture_window(32'h5F3A_1200, "recapture");
    endtask

    initial begin
        rst_n                  = 1'b0;
        hash_i                 = 64'h0123_4567_89AB_CDEF;
        usr_access_data_i      = 32'h0;
        usr_access_datavalid_i = 1'b0;
        user_words_i           = {32'hCAFE_F00D, 32'h1234_5678};
        rd_req_i               = 1'b0;
        rd_addr_i              = 4'd0;

        test_reset();
        test_back_to_back();
        test_hash();
        test_range_and_user();
        test_short_pulse();
        test_data_change();
        test_capture();
        test_reset_mid();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
